// File: rtl/regfile_sb_if.sv
// Register file access bus: read ports, ALU/load-return writes, load issue, scoreboard status.
interface regfile_sb_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
);
  logic [AW-1:0]   a1;
  logic [AW-1:0]   a2;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic            busy1;
  logic            busy2;
  logic            we;
  logic [AW-1:0]   a3;
  logic [XLEN-1:0] wd3;
  logic            we_ld;
  logic [AW-1:0]   a_ld;
  logic [XLEN-1:0] wd_ld;
  logic            iss_ld;
  logic [AW-1:0]   iss_a;
  logic [AW:0]     pend_cnt;

  modport master (
    output a1, a2, we, a3, wd3, we_ld, a_ld, wd_ld, iss_ld, iss_a,
    input  rd1, rd2, busy1, busy2, pend_cnt
  );

  modport slave (
    input  a1, a2, we, a3, wd3, we_ld, a_ld, wd_ld, iss_ld, iss_a,
    output rd1, rd2, busy1, busy2, pend_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with write-to-read bypass and a per-register load scoreboard.
module regfile_sb #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_sb_if.slave  bus
);

  localparam int unsigned CW = AW + 1;

  // Entry 0 is held at zero and never written, so synthesis folds it away.
  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] mem_d [NREG];
  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;

  logic ld_v;
  logic iss_v;
  logic inc;
  logic dec;

  // Read mux: r0 reads zero, ALU write beats load return, then stored value.
  function automatic logic [XLEN-1:0] rd_mux(
    input logic [AW-1:0]   a,
    input logic            we,
    input logic [AW-1:0]   a3,
    input logic [XLEN-1:0] wd3,
    input logic            we_ld,
    input logic [AW-1:0]   a_ld,
    input logic [XLEN-1:0] wd_ld,
    input logic [XLEN-1:0] stored
  );
    logic [XLEN-1:0] r;
    r = stored;
    if (a == '0)                     r = '0;
    else if (we && (a3 == a))        r = wd3;
    else if (we_ld && (a_ld == a))   r = wd_ld;
    return r;
  endfunction

  // Next-state for storage, pending bits and pending count.
  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    ld_v   = bus.we_ld && (bus.a_ld != '0);
    iss_v  = bus.iss_ld && (bus.iss_a != '0);

    // Load return first so a same-address ALU write overrides it.
    if (ld_v)                 mem_d[bus.a_ld] = bus.wd_ld;
    if (bus.we && (bus.a3 != '0)) mem_d[bus.a3] = bus.wd3;
    mem_d[0] = '0;

    // Clear before set so a new issue to a returning register stays pending.
    if (ld_v)  pend_d[bus.a_ld] = 1'b0;
    if (iss_v) pend_d[bus.iss_a] = 1'b1;
    pend_d[0] = 1'b0;

    // Count only real bit transitions.
    inc   = iss_v && pend_d[bus.iss_a] && !pend_q[bus.iss_a];
    dec   = ld_v && !pend_d[bus.a_ld] && pend_q[bus.a_ld];
    cnt_d = cnt_q + CW'(inc) - CW'(dec);
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) mem_q[i] <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  // Combinational read data and busy flags, masked by a same-cycle load return.
  always_comb begin
    bus.rd1 = rd_mux(bus.a1, bus.we, bus.a3, bus.wd3, bus.we_ld, bus.a_ld, bus.wd_ld,
                     mem_q[bus.a1]);
    bus.rd2 = rd_mux(bus.a2, bus.we, bus.a3, bus.wd3, bus.we_ld, bus.a_ld, bus.wd_ld,
                     mem_q[bus.a2]);
    bus.busy1 = (bus.a1 != '0) && pend_q[bus.a1] && !(bus.we_ld && (bus.a_ld == bus.a1));
    bus.busy2 = (bus.a2 != '0) && pend_q[bus.a2] && !(bus.we_ld && (bus.a_ld == bus.a2));
    bus.pend_cnt = cnt_q;
  end

endmodule
